decode_queue: RTL and testbench

- Decoupling FIFO between the decode stage and the backend register-read latch.
- Accepts one decoded instruction bundle per cycle from decode.
- Presents the oldest bundle to the backend on the i_* bundle inputs.
- Absorbs rrstall back-pressure, and is flushed on branch mispredict or code-segment invalidate so no wrong-path op reaches RR.

---
 rtl/decode_pkg.sv | 73 +++++++
 rtl/dq_ctrl.sv | 60 ++++++
 rtl/decode_queue.sv | 63 ++++++
 tb/tb_decode_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode-bundle definitions: payload width, queue depth and field layout,
// so decode packing and backend unpacking agree on one set of offsets.
package decode_pkg;

    localparam int BW       = 266;
    localparam int DQ_DEPTH = 4;

    // Field widths, listed from the LSB end of the packed bundle upwards.
    localparam int BPID_W     = 4;
    localparam int DFLAG_W    = 1;
    localparam int INDIR_W    = 1;
    localparam int BPTAKEN_W  = 1;
    localparam int SEGR2_W    = 3;
    localparam int SEGR1_W    = 3;
    localparam int IDX_W      = 3;
    localparam int BASE_W     = 3;
    localparam int SR2_W      = 3;
    localparam int SR1_W      = 3;
    localparam int OPSIZE_W   = 2;
    localparam int IMM8_W     = 8;
    localparam int BPTGT_W    = 32;
    localparam int EIP_W      = 32;
    localparam int NEIP_W     = 32;
    localparam int IDXREN_W   = 1;
    localparam int BASEREN_W  = 1;
    localparam int SCALE_W    = 2;
    localparam int ISSIB_W    = 1;
    localparam int DISPSIZE_W = 2;
    localparam int IMMSIZE_W  = 2;
    localparam int DISP_W     = 32;
    localparam int IMM_W      = 32;
    localparam int CS_W       = 62;

    localparam int BPID_LSB     = 0;
    localparam int DFLAG_LSB    = BPID_LSB     + BPID_W;
    localparam int INDIR_LSB    = DFLAG_LSB    + DFLAG_W;
    localparam int BPTAKEN_LSB  = INDIR_LSB    + INDIR_W;
    localparam int SEGR2_LSB    = BPTAKEN_LSB  + BPTAKEN_W;
    localparam int SEGR1_LSB    = SEGR2_LSB    + SEGR2_W;
    localparam int IDX_LSB      = SEGR1_LSB    + SEGR1_W;
    localparam int BASE_LSB     = IDX_LSB      + IDX_W;
    localparam int SR2_LSB      = BASE_LSB     + BASE_W;
    localparam int SR1_LSB      = SR2_LSB      + SR2_W;
    localparam int OPSIZE_LSB   = SR1_LSB      + SR1_W;
    localparam int IMM8_LSB     = OPSIZE_LSB   + OPSIZE_W;
    localparam int BPTGT_LSB    = IMM8_LSB     + IMM8_W;
    localparam int EIP_LSB      = BPTGT_LSB    + BPTGT_W;
    localparam int NEIP_LSB     = EIP_LSB      + EIP_W;
    localparam int IDXREN_LSB   = NEIP_LSB     + NEIP_W;
    localparam int BASEREN_LSB  = IDXREN_LSB   + IDXREN_W;
    localparam int SCALE_LSB    = BASEREN_LSB  + BASEREN_W;
    localparam int ISSIB_LSB    = SCALE_LSB    + SCALE_W;
    localparam int DISPSIZE_LSB = ISSIB_LSB    + ISSIB_W;
    localparam int IMMSIZE_LSB  = DISPSIZE_LSB + DISPSIZE_W;
    localparam int DISP_LSB     = IMMSIZE_LSB  + IMMSIZE_W;
    localparam int IMM_LSB      = DISP_LSB     + DISP_W;
    localparam int CS_LSB       = IMM_LSB      + IMM_W;

    typedef logic [BW-1:0] bundle_t;

    // Queue operation in a cycle, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } dq_op_e;

    function automatic logic [EIP_W-1:0] bundle_eip(input bundle_t b);
        return b[EIP_LSB +: EIP_W];
    endfunction

endpackage

// File: rtl/dq_ctrl.sv
// Pointer, occupancy and flush control for the decode queue; decides push/pop
// each cycle from registered state so d_stall never depends on rrstall.
module dq_ctrl
    import decode_pkg::*;
#(
    parameter int DEPTH = DQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       d_v,
    input  logic                       rrstall,
    input  logic                       flush,
    output logic                       push,
    output logic                       pop,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       d_stall
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    dq_op_e op;

    assign d_stall = (count == FULL);
    assign push    = d_v & ~d_stall & ~flush;
    assign pop     = (count != '0) & ~rrstall & ~flush;
    assign op      = dq_op_e'({push, pop});

    // Flush wins over everything: wrong-path input is dropped and no pop is counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            case (op)
                OP_PUSH: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    count  <= count + 1'b1;
                end
                OP_POP: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= count - 1'b1;
                end
                OP_BOTH: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Decoupling FIFO between decode and the backend RR latch: registered storage
// with the oldest bundle presented combinationally from state, no bypass.
module decode_queue #(
    parameter int DEPTH = decode_pkg::DQ_DEPTH,
    parameter int BW    = decode_pkg::BW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     d_v,
    input  logic [BW-1:0]            d_bundle,
    output logic                     d_stall,
    input  logic                     rrstall,
    input  logic                     flush,
    output logic                     o_v,
    output logic [BW-1:0]            o_bundle,
    output logic                     q_empty,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = $clog2(DEPTH);

    logic          push;
    logic          pop;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [BW-1:0] mem [DEPTH];

    // Head advance is already reflected in rd_ptr; pop itself is not needed here.
    logic unused_pop;
    assign unused_pop = pop;

    dq_ctrl #(
        .DEPTH(DEPTH)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .d_v     (d_v),
        .rrstall (rrstall),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .count   (q_count),
        .d_stall (d_stall)
    );

    // Clearing storage on reset makes o_bundle read zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= d_bundle;
        end
    end

    assign o_bundle = mem[rd_ptr];
    assign o_v      = (q_count != '0);
    assign q_empty  = ~o_v;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed vector table plus hand-written
// sequences for wrap-around ordering and asynchronous reset.
module tb_decode_queue;
    import decode_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          d_v;
    logic [BW-1:0] d_bundle;
    logic          d_stall;
    logic          rrstall;
    logic          flush;
    logic          o_v;
    logic [BW-1:0] o_bundle;
    logic          q_empty;
    logic [CW-1:0] q_count;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string         name;
        logic          dv;
        logic [31:0]   eip;
        logic          rrs;
        logic          fl;
        logic          exp_v;
        logic [CW-1:0] exp_cnt;
        logic          exp_stall;
        logic [31:0]   exp_eip;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH), .BW(BW)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_v      (d_v),
        .d_bundle (d_bundle),
        .d_stall  (d_stall),
        .rrstall  (rrstall),
        .flush    (flush),
        .o_v      (o_v),
        .o_bundle (o_bundle),
        .q_empty  (q_empty),
        .q_count  (q_count)
    );

    // Spread the EIP over several fields so the whole payload width is exercised.
    function automatic logic [BW-1:0] make_bundle(input logic [31:0] eip);
        logic [BW-1:0] b;
        b = '0;
        b[EIP_LSB +: EIP_W]   = eip;
        b[NEIP_LSB +: NEIP_W] = eip + 32'd1;
        b[CS_LSB +: 32]       = ~eip;
        b[BPID_LSB +: BPID_W] = eip[3:0];
        return b;
    endfunction

    task automatic addVec(input string name, input logic dv, input logic [31:0] eip,
                          input logic rrs, input logic fl, input logic exp_v,
                          input logic [CW-1:0] exp_cnt, input logic exp_stall,
                          input logic [31:0] exp_eip);
        vec_t v;
        v.name = name; v.dv = dv; v.eip = eip; v.rrs = rrs; v.fl = fl;
        v.exp_v = exp_v; v.exp_cnt = exp_cnt; v.exp_stall = exp_stall; v.exp_eip = exp_eip;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic dv, input logic [31:0] eip,
                                 input logic rrs, input logic fl);
        d_v      = dv;
        d_bundle = make_bundle(eip);
        rrstall  = rrs;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic exp_v,
                               input logic [CW-1:0] exp_cnt, input logic exp_stall,
                               input logic [31:0] exp_eip);
        logic [CW+2:0] act;
        logic [CW+2:0] exp;
        act = {o_v, q_empty, d_stall, q_count};
        exp = {exp_v, ~exp_v, exp_stall, exp_cnt};
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s status: got v=%0b empty=%0b stall=%0b count=%0d, want v=%0b empty=%0b stall=%0b count=%0d",
                     name, o_v, q_empty, d_stall, q_count, exp_v, ~exp_v, exp_stall, exp_cnt);
        end
        if (exp_v) begin
            n_cmp++;
            if (o_bundle !== make_bundle(exp_eip)) begin
                n_fail++;
                $display("[TB] FAIL %s head: got EIP=%h, want EIP=%h (or other field bits differ)",
                         name, bundle_eip(o_bundle), exp_eip);
            end
        end
    endtask

    task automatic checkZeroBundle(input string name);
        n_cmp++;
        if (o_bundle !== '0) begin
            n_fail++;
            $display("[TB] FAIL %s bundle: got EIP=%h nonzero, want all zero", name, bundle_eip(o_bundle));
        end
    endtask

    initial begin
        // Streaming: one push per cycle, head follows one cycle later.
        addVec("stream0", 1, 32'h1000, 0, 0, 1, 1, 0, 32'h1000);
        addVec("stream1", 1, 32'h1002, 0, 0, 1, 1, 0, 32'h1002);
        addVec("stream2", 1, 32'h1005, 0, 0, 1, 1, 0, 32'h1005);
        addVec("stream3", 1, 32'h1009, 0, 0, 1, 1, 0, 32'h1009);
        addVec("stream_drain", 0, 0, 0, 0, 0, 0, 0, 0);
        // Fill under rrstall, fifth bundle held, then drain in order.
        addVec("fill0", 1, 32'h10, 1, 0, 1, 1, 0, 32'h10);
        addVec("fill1", 1, 32'h11, 1, 0, 1, 2, 0, 32'h10);
        addVec("fill2", 1, 32'h12, 1, 0, 1, 3, 0, 32'h10);
        addVec("fill3", 1, 32'h13, 1, 0, 1, 4, 1, 32'h10);
        addVec("full_hold", 1, 32'h14, 1, 0, 1, 4, 1, 32'h10);
        addVec("full_pop_no_push", 1, 32'h14, 0, 0, 1, 3, 0, 32'h11);
        addVec("push_and_pop", 1, 32'h14, 0, 0, 1, 3, 0, 32'h12);
        addVec("drain13", 0, 0, 0, 0, 1, 2, 0, 32'h13);
        addVec("drain14", 0, 0, 0, 0, 1, 1, 0, 32'h14);
        addVec("drained", 0, 0, 0, 0, 0, 0, 0, 0);
        // Flush with a wrong-path push in the same cycle.
        addVec("pre_flush0", 1, 32'h20, 1, 0, 1, 1, 0, 32'h20);
        addVec("pre_flush1", 1, 32'h21, 1, 0, 1, 2, 0, 32'h20);
        addVec("pre_flush2", 1, 32'h22, 1, 0, 1, 3, 0, 32'h20);
        addVec("flush", 1, 32'h99, 0, 1, 0, 0, 0, 0);
        addVec("after_flush_push", 1, 32'h200, 0, 0, 1, 1, 0, 32'h200);
        addVec("after_flush_drain", 0, 0, 0, 0, 0, 0, 0, 0);
        addVec("empty_no_underflow", 0, 0, 0, 0, 0, 0, 0, 0);

        rst = 1'b0; d_v = 1'b0; rrstall = 1'b0; flush = 1'b0; d_bundle = '0;
        #1 rst = 1'b1;
        #1;
        checkOutput("reset", 0, 0, 0, 0);
        checkZeroBundle("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("idle", 0, 0, 0, 0);
        end

        // No same-cycle bypass: offering a bundle must not change o_v before the edge.
        d_v = 1'b1; d_bundle = make_bundle(32'h1000);
        #1;
        checkOutput("no_bypass", 0, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].dv, vecs[i].eip, vecs[i].rrs, vecs[i].fl);
            checkOutput(vecs[i].name, vecs[i].exp_v, vecs[i].exp_cnt, vecs[i].exp_stall, vecs[i].exp_eip);
        end

        // Wrap-around against a scoreboard with random back-pressure.
        begin
            logic [BW-1:0] sb[$];
            int pushed;
            int mcount;
            bit done;
            pushed = 0; mcount = 0; done = 0;
            for (int cyc = 0; cyc < 200 && !done; cyc++) begin
                logic dv;
                logic rrs;
                logic push_ok;
                logic pop_ok;
                dv  = (pushed < 11);
                rrs = 1'($urandom_range(0, 1));
                d_v = dv; d_bundle = make_bundle(32'h300 + pushed); rrstall = rrs; flush = 1'b0;
                n_cmp++;
                if ({o_v, q_count} !== {mcount != 0, mcount[CW-1:0]}) begin
                    n_fail++;
                    $display("[TB] FAIL wrap_status: got v=%0b count=%0d, want v=%0b count=%0d",
                             o_v, q_count, mcount != 0, mcount);
                end
                if (mcount != 0) begin
                    n_cmp++;
                    if (o_bundle !== sb[0]) begin
                        n_fail++;
                        $display("[TB] FAIL wrap_order: got EIP=%h, want EIP=%h",
                                 bundle_eip(o_bundle), bundle_eip(sb[0]));
                    end
                end
                push_ok = dv && (mcount != DEPTH);
                pop_ok  = (mcount != 0) && !rrs;
                @(posedge clk);
                #1;
                if (pop_ok) void'(sb.pop_front());
                if (push_ok) begin
                    sb.push_back(d_bundle);
                    pushed++;
                end
                mcount = mcount + int'(push_ok) - int'(pop_ok);
                if (pushed == 11 && mcount == 0) done = 1;
            end
            n_cmp++;
            if (!done) begin
                n_fail++;
                $display("[TB] FAIL wrap_timeout: got pushed=%0d pending=%0d, want pushed=11 pending=0",
                         pushed, mcount);
            end
            d_v = 1'b0; rrstall = 1'b0;
        end

        // Asynchronous reset between clock edges with two entries held.
        applyStimulus(1, 32'h400, 1, 0);
        applyStimulus(1, 32'h401, 1, 0);
        checkOutput("pre_reset", 1, 2, 0, 32'h400);
        d_v = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset", 0, 0, 0, 0);
        checkZeroBundle("async_reset");
        #2 rst = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("post_reset", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
